// File: rtl/seg_scan_drive.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous update.
// Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_drive #(
   parameter int DIGITS   = 6,
   parameter int SCAN_CNT = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_vld,
   input  logic [4*DIGITS-1:0]   display_data,
   input  logic [DIGITS-1:0]     dot_en,
   output logic [DIGITS-1:0]     sel,
   output logic [7:0]            seg,
   output logic                  frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(SCAN_CNT);
   localparam int DW = 4 * DIGITS;

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DW-1:0]     pend_data_q, pend_data_d;
   logic [DIGITS-1:0] pend_dot_q, pend_dot_d;
   logic [DW-1:0]     act_data_q, act_data_d;
   logic [DIGITS-1:0] act_dot_q, act_dot_d;
   logic              pend_flag_q, pend_flag_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   logic [7:0]        seg_q, seg_d;
   logic              fd_q;

   logic              last_cnt, last_idx, wrap;
   logic [3:0]        cur_nib;
   logic              cur_dot, cur_blank;
   logic [DIGITS-1:0] blank;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         4'hF: g = 7'h0E;
      endcase
      return g;
   endfunction

   assign last_cnt = (cnt_q == CW'(SCAN_CNT - 1));
   assign last_idx = (idx_q == IW'(DIGITS - 1));
   assign wrap     = last_cnt && last_idx;

   always_comb begin
      cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (last_cnt)
         idx_d = last_idx ? '0 : idx_q + 1'b1;
   end

   // Incoming data waits in pend_* until the frame wraps, so a frame never tears.
   always_comb begin
      pend_data_d = data_vld ? display_data : pend_data_q;
      pend_dot_d  = data_vld ? dot_en : pend_dot_q;
      act_data_d  = act_data_q;
      act_dot_d   = act_dot_q;
      pend_flag_d = pend_flag_q;
      if (wrap) begin
         pend_flag_d = 1'b0;
         if (data_vld) begin
            act_data_d = display_data;
            act_dot_d  = dot_en;
         end else if (pend_flag_q) begin
            act_data_d = pend_data_q;
            act_dot_d  = pend_dot_q;
         end
      end else if (data_vld) begin
         pend_flag_d = 1'b1;
      end
   end

`ifdef SEG_LZB_EN
   logic lead;
   always_comb begin
      lead  = 1'b1;
      blank = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lead     = lead && (act_data_q[4*i +: 4] == 4'h0) && !act_dot_q[i];
         blank[i] = lead;
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      cur_nib   = '0;
      cur_dot   = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib   = act_data_q[4*i +: 4];
            cur_dot   = act_dot_q[i];
            cur_blank = blank[i];
         end
      end
   end

   assign sel_d = ~(DIGITS'(1) << idx_q);
   assign seg_d = cur_blank ? 8'hFF : {~cur_dot, glyph(cur_nib)};

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         pend_data_q <= '0;
         pend_dot_q  <= '0;
         act_data_q  <= '0;
         act_dot_q   <= '0;
         pend_flag_q <= 1'b0;
         sel_q       <= '1;
         seg_q       <= 8'hFF;
         fd_q        <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pend_data_q <= pend_data_d;
         pend_dot_q  <= pend_dot_d;
         act_data_q  <= act_data_d;
         act_dot_q   <= act_dot_d;
         pend_flag_q <= pend_flag_d;
         sel_q       <= sel_d;
         seg_q       <= seg_d;
         fd_q        <= wrap;
      end
   end

   assign sel        = sel_q;
   assign seg        = seg_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_drive.sv
// Self-checking bench for seg_scan_drive (DIGITS=6, SCAN_CNT=4).
// Reference model tracks frame position and displayed/pending words abstractly.
module tb_seg_scan_drive;

   localparam int D = 6;
   localparam int S = 4;
   localparam int F = D * S;

   logic          clk = 1'b0;
   logic          rst;
   logic          data_vld;
   logic [23:0]   display_data;
   logic [5:0]    dot_en;
   logic [5:0]    sel;
   logic [7:0]    seg;
   logic          frame_done;

   int n_assert = 0;
   int n_fail   = 0;

   int         pos;
   logic [23:0] shown_data, pend_data;
   logic [5:0]  shown_dot, pend_dot;
   bit          have_pend;

   logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   seg_scan_drive #(.DIGITS(D), .SCAN_CNT(S)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_vld     (data_vld),
      .display_data (display_data),
      .dot_en       (dot_en),
      .sel          (sel),
      .seg          (seg),
      .frame_done   (frame_done)
   );

   function automatic logic [3:0] nib_of(input logic [23:0] w, input int d);
      logic [23:0] t;
      t = w >> (4 * d);
      return t[3:0];
   endfunction

   function automatic logic [7:0] exp_glyph(input int d);
      bit blank;
      blank = 1'b0;
`ifdef SEG_LZB_EN
      if (d > 0) begin
         blank = 1'b1;
         for (int j = d; j < D; j++)
            if (nib_of(shown_data, j) != 4'h0 || shown_dot[j])
               blank = 1'b0;
      end
`endif
      if (blank) return 8'hFF;
      return {~shown_dot[d], tbl[nib_of(shown_data, d)]};
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%h exp=%h pos=%0d", tag, got, exp, pos);
      end
   endtask

   task automatic step(input logic r, input logic v,
                       input logic [23:0] d, input logic [5:0] dt);
      logic [5:0] e_sel;
      logic [7:0] e_seg;
      logic       e_fd;
      rst          = r;
      data_vld     = v;
      display_data = d;
      dot_en       = dt;
      @(posedge clk);
      if (r) begin
         e_sel      = 6'h3F;
         e_seg      = 8'hFF;
         e_fd       = 1'b0;
         pos        = 0;
         shown_data = '0;
         shown_dot  = '0;
         pend_data  = '0;
         pend_dot   = '0;
         have_pend  = 1'b0;
      end else begin
         e_sel = ~(6'd1 << (pos / S));
         e_seg = exp_glyph(pos / S);
         e_fd  = (pos == F - 1);
         if (v) begin
            pend_data = d;
            pend_dot  = dt;
            have_pend = 1'b1;
         end
         if (pos == F - 1 && have_pend) begin
            shown_data = pend_data;
            shown_dot  = pend_dot;
            have_pend  = 1'b0;
         end
         pos = (pos + 1) % F;
      end
      #1;
      chk("sel", {2'b00, sel}, {2'b00, e_sel});
      chk("seg", seg, e_seg);
      chk("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 6'h0);
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < F && pos != target; i++) step(1'b0, 1'b0, 24'h0, 6'h0);
   endtask

   task automatic load(input logic [23:0] d, input logic [5:0] dt);
      step(1'b0, 1'b1, d, dt);
   endtask

   initial begin
      pos = 0;
      shown_data = '0; shown_dot = '0;
      pend_data = '0; pend_dot = '0; have_pend = 1'b0;
      step(1'b1, 1'b0, 24'h0, 6'h0);
      step(1'b1, 1'b0, 24'h0, 6'h0);
      // reset scan: two full frames of zeros
      idle(2 * F);
      // tear-free update mid-frame at digit 2
      run_to(2 * S + 2);
      load(24'h123456, 6'h00);
      idle(2 * F + 5);
      // coincident load on the wrap cycle
      run_to(F - 1);
      load(24'h000009, 6'h00);
      idle(F + 3);
      // dots and leading zeros
      run_to(7);
      load(24'h000105, 6'b000100);
      idle(2 * F);
      // glyph sweep across all digits
      run_to(3);
      load(24'hFEDCBA, 6'h00);
      idle(F + 2);
      load(24'h987654, 6'h2A);
      idle(F + 2);
      load(24'h3210FE, 6'h00);
      idle(F + 2);
      // two loads in one frame: the last one wins
      run_to(1);
      load(24'h111111, 6'h3F);
      idle(5);
      load(24'h0000A0, 6'h00);
      idle(2 * F);
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic r, v;
         r = ($urandom_range(0, 499) == 0);
         v = ($urandom_range(0, 15) == 0);
         step(r, v, 24'($urandom), 6'($urandom));
      end
      // reset mid-frame at digit 3
      run_to(3 * S + 1);
      load(24'h777777, 6'h3F);
      idle(F);
      run_to(3 * S + 1);
      step(1'b1, 1'b0, 24'h0, 6'h0);
      idle(2 * F);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
